// File: rtl/trivium_pkg.sv
`timescale 1ns/1ps
// trivium_pkg: shared constants, tap positions and FSM encoding for the
// Trivium stream-cipher datapath (trivium_step) and its wrapper (trivium_xcrypt).
// Cipher state bits are numbered s1..s288 and held in vectors of type
// logic [TRIV_N:1], so that bit k of the vector is s_k.
package trivium_pkg;

    localparam int TRIV_N     = 288;   // cipher state width
    localparam int INIT_STEPS = 1152;  // warm-up steps (4 full state cycles)

    // Output taps
    localparam int T1_A = 66;
    localparam int T1_B = 93;
    localparam int T2_A = 162;
    localparam int T2_B = 177;
    localparam int T3_A = 243;
    localparam int T3_B = 288;

    // Nonlinear AND pairs
    localparam int A1_X = 91;
    localparam int A1_Y = 92;
    localparam int A2_X = 175;
    localparam int A2_Y = 176;
    localparam int A3_X = 286;
    localparam int A3_Y = 287;

    // Cross-register feed taps
    localparam int F1 = 171;
    localparam int F2 = 264;
    localparam int F3 = 69;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INIT    = 2'd1,
        ST_RUN     = 2'd2,
        ST_EXHAUST = 2'd3
    } state_e;

    // Keystream width must divide 1152 and stay a power of two up to 64.
    function automatic bit legal_w(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
               (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/trivium_step.sv
`timescale 1ns/1ps
// trivium_step: purely combinational W-step Trivium state advance.
// Ports:
//   i_state [288:1] : current cipher state (bit k = s_k)
//   o_state [288:1] : state after W steps
//   o_z     [W-1:0] : keystream bits, o_z[i] produced by step i (i=0 first)
module trivium_step
    import trivium_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [TRIV_N:1] i_state,
    output logic [TRIV_N:1] o_state,
    output logic [W-1:0]    o_z
);

    always_comb begin : p_step
        logic [TRIV_N:1] s;
        logic            t1;
        logic            t2;
        logic            t3;
        s   = i_state;
        o_z = '0;
        t1  = 1'b0;
        t2  = 1'b0;
        t3  = 1'b0;
        for (int i = 0; i < W; i++) begin
            t1     = s[T1_A] ^ s[T1_B];
            t2     = s[T2_A] ^ s[T2_B];
            t3     = s[T3_A] ^ s[T3_B];
            o_z[i] = t1 ^ t2 ^ t3;
            t1     = t1 ^ (s[A1_X] & s[A1_Y]) ^ s[F1];
            t2     = t2 ^ (s[A2_X] & s[A2_Y]) ^ s[F2];
            t3     = t3 ^ (s[A3_X] & s[A3_Y]) ^ s[F3];
            // Each of the three registers (s1..s93, s94..s177, s178..s288)
            // shifts up by one; the dropped top bit is replaced by the feedback
            // of the preceding register: s1<-t3, s94<-t1, s178<-t2.
            s      = {s[287:178], t2, s[176:94], t1, s[92:1], t3};
        end
        o_state = s;
    end

endmodule

// File: rtl/trivium_xcrypt.sv
`timescale 1ns/1ps
// trivium_xcrypt: Trivium keystream XOR engine with valid/ready streaming.
// Ports:
//   clk, rst (async, active-high)
//   key_i[79:0], iv_i[79:0] : sampled when load_i=1 (load restarts from any state)
//   busy_o     : initialisation (1152 warm-up steps) in progress
//   key_ok_o   : keystream available (RUN)
//   din_valid_i/din_ready_o/din_i[W-1:0]    : input words
//   dout_valid_o/dout_ready_i/dout_o[W-1:0] : din XOR keystream, 1-cycle latency
//   err_o      : sticky; word counter wrapped, or data offered before a key
module trivium_xcrypt
    import trivium_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [79:0]  key_i,
    input  logic [79:0]  iv_i,
    input  logic         load_i,
    output logic         busy_o,
    output logic         key_ok_o,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    input  logic [W-1:0] din_i,
    output logic         dout_valid_o,
    input  logic         dout_ready_i,
    output logic [W-1:0] dout_o,
    output logic         err_o
);

    localparam int INIT_CYC = INIT_STEPS / W;

    generate
        if (!legal_w(W)) begin : g_illegal_w
            $error("trivium_xcrypt: W must be one of 1,2,4,8,16,32,64");
        end
    endgenerate

    state_e          r_fsm;
    state_e          w_fsm_nxt;
    logic [TRIV_N:1] r_state;
    logic [TRIV_N:1] w_state_nxt;
    logic [TRIV_N:1] w_load_state;
    logic [W-1:0]    w_z;
    logic [W-1:0]    r_dout;
    logic            r_dout_vld;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [10:0]     r_init_cnt;
    logic            r_err;
    logic            w_busy;
    logic            w_key_ok;
    logic            w_din_rdy;
    logic            w_din_hs;
    logic            w_wrap;
    logic            w_init_done;

    trivium_step #(.W(W)) u_step (
        .i_state (r_state),
        .o_state (w_state_nxt),
        .o_z     (w_z)
    );

    // s1..s80=key, s94..s173=iv, s286..s288=1, everything else 0.
    assign w_load_state = {3'b111, 108'd0, 4'd0, iv_i, 13'd0, key_i};

    assign w_din_rdy   = (r_fsm == ST_RUN) && (!r_dout_vld || dout_ready_i);
    // A load in the same cycle takes priority: the offered word is not consumed.
    assign w_din_hs    = w_din_rdy && din_valid_i && !load_i;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_wrap      = (w_cnt_inc == '0);
    assign w_init_done = (r_init_cnt == 11'(INIT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        w_busy    = 1'b0;
        w_key_ok  = 1'b0;
        case (r_fsm)
            ST_INIT: begin
                w_busy = 1'b1;
                if (w_init_done) begin
                    w_fsm_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_key_ok = 1'b1;
                if (w_din_hs && w_wrap) begin
                    w_fsm_nxt = ST_EXHAUST;
                end
            end
            default: begin
            end
        endcase
        if (load_i) begin
            w_fsm_nxt = ST_INIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= '0;
            r_cnt      <= '0;
            r_init_cnt <= '0;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_err      <= 1'b0;
        end else if (load_i) begin
            // Restart: any pending output word is dropped.
            r_state    <= w_load_state;
            r_cnt      <= '0;
            r_init_cnt <= '0;
            r_dout_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_fsm == ST_INIT) begin
                r_state    <= w_state_nxt;
                r_init_cnt <= r_init_cnt + 11'd1;
            end
            if (w_din_hs) begin
                r_state    <= w_state_nxt;
                r_dout     <= din_i ^ w_z;
                r_cnt      <= w_cnt_inc;
                r_dout_vld <= 1'b1;
            end else if (dout_ready_i) begin
                r_dout_vld <= 1'b0;
            end
            if ((w_din_hs && w_wrap) ||
                (din_valid_i && ((r_fsm == ST_IDLE) || (r_fsm == ST_INIT)))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_o       = w_busy;
    assign key_ok_o     = w_key_ok;
    assign din_ready_o  = w_din_rdy;
    assign dout_valid_o = r_dout_vld;
    assign dout_o       = r_dout;
    assign err_o        = r_err;

endmodule

// File: tb/tb_trivium_xcrypt.sv
`timescale 1ns/1ps
// Bench for trivium_xcrypt: three instances (W=8/CNT_W=32, W=1/CNT_W=32,
// W=64/CNT_W=4) checked against a bit-serial Trivium reference model through
// per-instance scoreboards, plus a table of control/status vectors.
module tb_trivium_xcrypt;

    logic        clk;
    logic        rst;
    logic [79:0] key;
    logic [79:0] iv;

    logic       load_8, din_valid_8, dout_ready_8, busy_8, key_ok_8, din_ready_8, dout_valid_8, err_8;
    logic [7:0] din_8, dout_8;
    logic       load_1, din_valid_1, dout_ready_1, busy_1, key_ok_1, din_ready_1, dout_valid_1, err_1;
    logic [0:0] din_1, dout_1;
    logic        load_64, din_valid_64, dout_ready_64, busy_64, key_ok_64, din_ready_64, dout_valid_64, err_64;
    logic [63:0] din_64, dout_64;

    trivium_xcrypt #(.W(8), .CNT_W(32)) u8 (
        .clk(clk), .rst(rst), .key_i(key), .iv_i(iv), .load_i(load_8),
        .busy_o(busy_8), .key_ok_o(key_ok_8),
        .din_valid_i(din_valid_8), .din_ready_o(din_ready_8), .din_i(din_8),
        .dout_valid_o(dout_valid_8), .dout_ready_i(dout_ready_8), .dout_o(dout_8),
        .err_o(err_8));

    trivium_xcrypt #(.W(1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .key_i(key), .iv_i(iv), .load_i(load_1),
        .busy_o(busy_1), .key_ok_o(key_ok_1),
        .din_valid_i(din_valid_1), .din_ready_o(din_ready_1), .din_i(din_1),
        .dout_valid_o(dout_valid_1), .dout_ready_i(dout_ready_1), .dout_o(dout_1),
        .err_o(err_1));

    trivium_xcrypt #(.W(64), .CNT_W(4)) u64 (
        .clk(clk), .rst(rst), .key_i(key), .iv_i(iv), .load_i(load_64),
        .busy_o(busy_64), .key_ok_o(key_ok_64),
        .din_valid_i(din_valid_64), .din_ready_o(din_ready_64), .din_i(din_64),
        .dout_valid_o(dout_valid_64), .dout_ready_i(dout_ready_64), .dout_o(dout_64),
        .err_o(err_64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    localparam logic [79:0] K1 = 80'h0F62B5085BAE0154A7FA;
    localparam logic [79:0] V1 = 80'h288FF65DC42B92F960C7;

    logic [2047:0] ks_k0;   // keystream for key=0, iv=0 (bit j = z_{j+1})
    logic [2047:0] ks_k1;   // keystream for K1/V1
    bit            sel8;    // which keystream the W=8 scoreboard expects

    logic [63:0] q8[$];
    logic [63:0] q1[$];
    logic [63:0] q64[$];
    logic [7:0]  feed8[$];
    logic [7:0]  out8[$];
    logic [7:0]  ct[$];
    int kpos8, kpos1, kpos64;
    int nacc8, nacc1, nacc64;
    int nout8, nout1, nout64;
    bit         hold8_vld;
    logic [7:0] hold8;

    typedef struct {
        bit rst;
        bit load;
        bit dv;
        bit busy;
        bit kok;
        bit err;
        bit drdy;
    } row_t;
    row_t tbl[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=no-event required=event", nm);
    endtask

    // Bit-serial reference: Trivium as written in the cipher description.
    task automatic gen_ks(input logic [79:0] k, input logic [79:0] v, output logic [2047:0] ks);
        logic s[1:288];
        logic t1, t2, t3;
        ks = '0;
        for (int i = 1; i <= 288; i++) s[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
        for (int n = 0; n < 1152 + 2048; n++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            if (n >= 1152) ks[n - 1152] = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int j = 288; j > 178; j--) s[j] = s[j-1];
            s[178] = t2;
            for (int j = 177; j > 94; j--) s[j] = s[j-1];
            s[94] = t1;
            for (int j = 93; j > 1; j--) s[j] = s[j-1];
            s[1] = t3;
        end
    endtask

    // Called at the falling edge: inputs and outputs are stable for the next rising edge.
    task automatic mon();
        logic [2047:0] ks;
        logic [63:0]   e;
        if (rst) begin
            q8.delete(); q1.delete(); q64.delete();
            hold8_vld = 1'b0;
            return;
        end
        // W=8
        if (hold8_vld) begin
            check("u8_stall_valid", {63'd0, dout_valid_8}, 64'd1);
            check("u8_stall_data", {56'd0, dout_8}, {56'd0, hold8});
        end
        if (dout_valid_8 && dout_ready_8) begin
            if (q8.size() == 0) bad("u8_unexpected_dout");
            else begin
                e = q8.pop_front();
                check("u8_dout", {56'd0, dout_8}, e);
            end
            out8.push_back(dout_8);
            nout8++;
        end
        hold8_vld = dout_valid_8 && !dout_ready_8 && !load_8;
        hold8     = dout_8;
        if (load_8) begin
            q8.delete(); kpos8 = 0;
        end else if (din_valid_8 && din_ready_8) begin
            ks = (sel8 ? ks_k1 : ks_k0) >> kpos8;
            q8.push_back({56'd0, din_8 ^ ks[7:0]});
            kpos8 += 8; nacc8++;
            if (feed8.size() > 0) void'(feed8.pop_front());
        end
        // W=1
        if (dout_valid_1 && dout_ready_1) begin
            if (q1.size() == 0) bad("u1_unexpected_dout");
            else begin
                e = q1.pop_front();
                check("u1_dout", {63'd0, dout_1}, e);
            end
            nout1++;
        end
        if (load_1) begin
            q1.delete(); kpos1 = 0;
        end else if (din_valid_1 && din_ready_1) begin
            ks = ks_k0 >> kpos1;
            q1.push_back({63'd0, din_1 ^ ks[0]});
            kpos1 += 1; nacc1++;
        end
        // W=64
        if (dout_valid_64 && dout_ready_64) begin
            if (q64.size() == 0) bad("u64_unexpected_dout");
            else begin
                e = q64.pop_front();
                check("u64_dout", dout_64, e);
            end
            nout64++;
        end
        if (load_64) begin
            q64.delete(); kpos64 = 0;
        end else if (din_valid_64 && din_ready_64) begin
            ks = ks_k0 >> kpos64;
            q64.push_back(din_64 ^ ks[63:0]);
            kpos64 += 64; nacc64++;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ko(input int which, input string nm);
        for (int c = 0; c < 1300; c++) begin
            if ((which == 8 && key_ok_8) || (which == 64 && key_ok_64)) return;
            cycle();
        end
        bad(nm);
    endtask

    task automatic run_feed8(input bit bp);
        for (int c = 0; c < 800; c++) begin
            if (feed8.size() == 0 && q8.size() == 0) break;
            din_valid_8  = (feed8.size() > 0);
            din_8        = (feed8.size() > 0) ? feed8[0] : 8'h00;
            dout_ready_8 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
        end
        din_valid_8  = 1'b0;
        dout_ready_8 = 1'b1;
        check("u8_feed_drained", 64'(feed8.size()), 64'd0);
        check("u8_sb_drained", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb8, nb1, nb64;
        checks = 0; failures = 0;
        rst = 1'b1; key = '0; iv = '0; sel8 = 1'b0;
        load_8 = 0; din_valid_8 = 0; din_8 = '0; dout_ready_8 = 1;
        load_1 = 0; din_valid_1 = 0; din_1 = '0; dout_ready_1 = 1;
        load_64 = 0; din_valid_64 = 0; din_64 = '0; dout_ready_64 = 1;
        kpos8 = 0; kpos1 = 0; kpos64 = 0;
        nacc8 = 0; nacc1 = 0; nacc64 = 0; nout8 = 0; nout1 = 0; nout64 = 0;
        hold8_vld = 1'b0; hold8 = '0;
        gen_ks(80'd0, 80'd0, ks_k0);
        gen_ks(K1, V1, ks_k1);
        cycle();

        // Control/status vectors on the W=8 instance:
        //            rst load dv  busy kok err drdy
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // data in IDLE
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // err sticky
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // load clears err
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}; // data in INIT
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int r = 0; r < 6; r++) begin
            rst = tbl[r].rst; load_8 = tbl[r].load; din_valid_8 = tbl[r].dv;
            cycle();
            check($sformatf("tbl%0d_busy", r), {63'd0, busy_8}, {63'd0, tbl[r].busy});
            check($sformatf("tbl%0d_keyok", r), {63'd0, key_ok_8}, {63'd0, tbl[r].kok});
            check($sformatf("tbl%0d_err", r), {63'd0, err_8}, {63'd0, tbl[r].err});
            check($sformatf("tbl%0d_dready", r), {63'd0, din_ready_8}, {63'd0, tbl[r].drdy});
            check($sformatf("tbl%0d_dvalid", r), {63'd0, dout_valid_8}, 64'd0);
        end
        load_8 = 0; din_valid_8 = 0;

        // Load key=0/iv=0 everywhere and measure initialisation length.
        load_8 = 1; load_1 = 1; load_64 = 1;
        cycle();
        load_8 = 0; load_1 = 0; load_64 = 0;
        nb8 = 0; nb1 = 0; nb64 = 0;
        for (int c = 0; c < 1300; c++) begin
            if (busy_8) nb8++;
            if (busy_1) nb1++;
            if (busy_64) nb64++;
            if (!busy_8 && !busy_1 && !busy_64) break;
            cycle();
        end
        check("u8_init_cycles", 64'(nb8), 64'd144);
        check("u1_init_cycles", 64'(nb1), 64'd1152);
        check("u64_init_cycles", 64'(nb64), 64'd18);
        check("u8_keyok", {63'd0, key_ok_8}, 64'd1);
        check("u1_keyok", {63'd0, key_ok_1}, 64'd1);
        check("u64_keyok", {63'd0, key_ok_64}, 64'd1);
        check("u8_err_after_load", {63'd0, err_8}, 64'd0);

        // Zero plaintext: dout is the raw keystream. W=64 runs into exhaustion.
        nacc8 = 0; nacc1 = 0; nacc64 = 0; nout8 = 0; nout1 = 0; nout64 = 0;
        for (int c = 0; c < 150; c++) begin
            din_valid_8  = (nacc8 < 64);  din_8  = '0;
            din_valid_1  = (nacc1 < 64);  din_1  = '0;
            din_valid_64 = (nacc64 < 20); din_64 = '0;
            cycle();
        end
        din_valid_8 = 0; din_valid_1 = 0; din_valid_64 = 0;
        cycle(); cycle();
        check("u8_words_in", 64'(nacc8), 64'd64);
        check("u8_words_out", 64'(nout8), 64'd64);
        check("u1_words_in", 64'(nacc1), 64'd64);
        check("u1_words_out", 64'(nout1), 64'd64);
        check("u64_words_in", 64'(nacc64), 64'd16);
        check("u64_words_out", 64'(nout64), 64'd16);
        check("u64_exh_err", {63'd0, err_64}, 64'd1);
        check("u64_exh_dready", {63'd0, din_ready_64}, 64'd0);
        check("u64_exh_keyok", {63'd0, key_ok_64}, 64'd0);
        check("u8_err_run", {63'd0, err_8}, 64'd0);

        // Leave EXHAUST with a fresh load.
        load_64 = 1;
        cycle();
        load_64 = 0;
        check("u64_reload_err", {63'd0, err_64}, 64'd0);
        check("u64_reload_busy", {63'd0, busy_64}, 64'd1);
        wait_ko(64, "u64_reload_keyok_timeout");
        nacc64 = 0;
        for (int c = 0; c < 10; c++) begin
            din_valid_64 = (nacc64 < 2);
            cycle();
        end
        din_valid_64 = 0;
        cycle();
        check("u64_reload_words", 64'(nacc64), 64'd2);

        // Encrypt 0x5A with random backpressure, then decrypt the ciphertext.
        sel8 = 1'b1; key = K1; iv = V1;
        load_8 = 1; cycle(); load_8 = 0;
        wait_ko(8, "u8_k1_keyok_timeout");
        out8.delete();
        for (int i = 0; i < 32; i++) feed8.push_back(8'h5A);
        run_feed8(1'b1);
        check("u8_ct_count", 64'(out8.size()), 64'd32);
        ct = out8;
        load_8 = 1; cycle(); load_8 = 0;
        wait_ko(8, "u8_k1_reload_timeout");
        out8.delete();
        feed8 = ct;
        run_feed8(1'b0);
        check("u8_pt_count", 64'(out8.size()), 64'd32);
        for (int i = 0; i < out8.size(); i++)
            check($sformatf("u8_pt%0d", i), {56'd0, out8[i]}, 64'h5A);

        // Load while an output word is pending.
        dout_ready_8 = 0; din_valid_8 = 1; din_8 = 8'h11;
        cycle();
        din_valid_8 = 0;
        check("u8_pending_valid", {63'd0, dout_valid_8}, 64'd1);
        cycle();
        load_8 = 1;
        cycle();
        load_8 = 0; dout_ready_8 = 1;
        check("u8_load_drop_valid", {63'd0, dout_valid_8}, 64'd0);
        check("u8_load_busy", {63'd0, busy_8}, 64'd1);
        wait_ko(8, "u8_k1_reload2_timeout");

        // Load and a din handshake in the same cycle: load wins.
        load_8 = 1; din_valid_8 = 1; din_8 = 8'h22;
        cycle();
        load_8 = 0; din_valid_8 = 0;
        check("u8_loadwin_valid", {63'd0, dout_valid_8}, 64'd0);
        check("u8_loadwin_busy", {63'd0, busy_8}, 64'd1);
        wait_ko(8, "u8_k1_reload3_timeout");
        for (int i = 0; i < 4; i++) feed8.push_back(8'h00);
        run_feed8(1'b0);
        check("u8_loadwin_err", {63'd0, err_8}, 64'd0);

        // Reset mid-RUN: back to IDLE, a new load is required.
        rst = 1;
        cycle();
        check("rst_run_keyok", {63'd0, key_ok_8}, 64'd0);
        check("rst_run_busy", {63'd0, busy_8}, 64'd0);
        check("rst_run_dready", {63'd0, din_ready_8}, 64'd0);
        check("rst_run_dout", {56'd0, dout_8}, 64'd0);
        check("rst_run_err", {63'd0, err_64 | err_8}, 64'd0);
        rst = 0; din_valid_8 = 1;
        cycle();
        din_valid_8 = 0;
        check("rst_idle_data_err", {63'd0, err_8}, 64'd1);
        check("rst_idle_dvalid", {63'd0, dout_valid_8}, 64'd0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trivium_xcrypt.md
TRIVIUM_XCRYPT -- requirements
Module: trivium_xcrypt

Interface
REQ-001 SHALL have parameter W, default 8; keystream bits per cycle; legal values 1,2,4,8,16,32,64.
REQ-002 SHALL have parameter CNT_W, default 32; width of the keystream word counter.
REQ-003 SHALL have ports clk, in, 1, the single clock; rst, in, 1, reset (asynchronous, active-high).
REQ-004 SHALL have ports key_i, in, 80, key, sampled on load; iv_i, in, 80, IV, sampled on load.
REQ-005 SHALL have ports load_i, in, 1, start key/IV load; busy_o, out, 1, initialisation in progress; key_ok_o, out, 1, keystream available.
REQ-006 SHALL have ports din_valid_i, in, 1; din_ready_o, out, 1; din_i, in, W, plaintext/ciphertext word.
REQ-007 SHALL have ports dout_valid_o, out, 1; dout_ready_i, in, 1; dout_o, out, W, din XOR keystream.
REQ-008 SHALL have ports err_o, out, 1, sticky: counter exhausted or data offered with no key.

Function
REQ-009 SHALL implement FSM states IDLE, INIT, RUN, EXHAUST.
REQ-010 SHALL load on load_i=1 in any state (abort and restart): s1..s80=key_i[0..79], s81..s93=0; s94..s173=iv_i[0..79], s174..s177=0; s178..s285=0, s286..s288=1; go to INIT.
REQ-011 SHALL in INIT advance the 288-bit state W steps per cycle, with no output, for exactly 1152/W cycles (144 at W=8), then enter RUN.
REQ-012 SHALL drive busy_o=1 only in INIT and key_ok_o=1 only in RUN.
REQ-013 SHALL drive din_ready_o = RUN and (not dout_valid_o or dout_ready_i).
REQ-014 SHALL on a din handshake advance the state W steps and register dout_o = din_i XOR z; keystream bit z(i) of step i maps to dout_o[i], and the first keystream bit is z1 of the Trivium spec.
REQ-015 SHALL assert dout_valid_o the cycle after the din handshake (latency 1); hold dout_o/dout_valid_o stable until dout_ready_i.
REQ-016 SHALL sustain one word per cycle when dout_ready_i is held at 1; cipher state advances only on din handshakes.
REQ-017 SHALL increment the word counter per din handshake; when it wraps to 0 (2^CNT_W words), go to EXHAUST and set err_o.
REQ-018 SHALL in EXHAUST hold din_ready_o=0; only load_i leaves EXHAUST.
REQ-019 SHALL set err_o when din_valid_i=1 in IDLE or INIT; such data is ignored.
REQ-020 SHALL clear err_o, the counter and dout_valid_o on load_i; a pending output word is discarded.
REQ-021 SHALL let load_i win over a simultaneous din handshake in the same cycle (word not consumed, no output).

Reset
REQ-022 SHALL on rst clear state, counter, dout_o, dout_valid_o, err_o and enter IDLE; busy_o, key_ok_o and din_ready_o are 0.
REQ-023 SHALL treat rst mid-INIT or mid-RUN identically; a new load_i is required afterwards.

Structure
REQ-024 SHALL put the FSM state enum, the 288-bit state width, the 1152-step init constant and the tap positions (66,93,162,177,243,288; AND pairs 91/92, 175/176, 286/287; feed 171, 264, 69) in package trivium_pkg.
REQ-025 SHALL use one combinational sub-module trivium_step (parameter W), returning the next state and the W keystream bits; shared by INIT and RUN.
REQ-026 SHALL reject illegal W at elaboration.

Verification
REQ-027 SHALL cover: W=8, load key=0, iv=0 -> busy_o high exactly 144 cycles, then key_ok_o=1; 64 bytes of din=0x00 -> dout equals the Trivium golden-model keystream.
REQ-028 SHALL cover: W=1 and W=64, same key/IV -> concatenated outputs identical to the W=8 stream bit-for-bit; init lasts 1152 and 18 cycles.
REQ-029 SHALL cover: encrypt 0x5A stream, reload the same key/IV, feed the ciphertext -> plaintext 0x5A recovered.
REQ-030 SHALL cover: random dout_ready_i backpressure (50%) -> no word lost or duplicated; dout_o stable while stalled.
REQ-031 SHALL cover: CNT_W=4 -> after 16 words, EXHAUST, err_o=1, din_ready_o=0; load_i clears err_o and reinitialises.
REQ-032 SHALL cover: din_valid_i during INIT -> err_o=1, no dout; load_i mid-RUN with pending dout -> dout_valid_o=0 next cycle, busy_o=1.
